// File: rtl/hsv_pkg.sv
// Shared widths, hue constants and the max-channel select type for the
// RGB -> HSV colour-space stage.
package hsv_pkg;

  localparam int H_W = 9;
  localparam int S_W = 7;
  localparam int V_W = 8;

  localparam int HUE_SEG     = 60;
  localparam int HUE_FULL    = 360;
  localparam int HUE_G_BASE  = 120;
  localparam int HUE_B_BASE  = 240;
  localparam int S_MAX       = 127;
  localparam int RGB2HSV_LAT = 4;

  // Which channel supplied the maximum; ties resolve R first, then G.
  typedef enum logic [1:0] {
    SEL_R,
    SEL_G,
    SEL_B
  } max_sel_e;

  // ceil(65536 / x), with x == 0 mapped to 0 so a zero divisor reads harmlessly.
  function automatic logic [31:0] recip_ceil(input logic [31:0] x);
    logic [31:0] q;
    if (x == 32'd0) q = 32'd0;
    else            q = (32'd65536 + x - 32'd1) / x;
    return q;
  endfunction

endpackage

// File: rtl/recip_lut.sv
// Reciprocal ROM: recip = ceil(65536 / addr), entry 0 reads as 0.
// Latency: combinational, zero cycles.
// Backpressure: none; pure table lookup.
module recip_lut
  import hsv_pkg::*;
#(
  parameter int RECIP_W = 17
) (
  input  logic [7:0]         addr,
  output logic [RECIP_W-1:0] recip
);

  logic [RECIP_W-1:0] rom [256];

  // Every entry is a constant, so this folds into a 256-word ROM.
  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = RECIP_W'(recip_ceil(32'(i)));
  end

  // Table read
  always_comb recip = rom[addr];

endmodule

// File: rtl/rgb_to_hsv.sv
// RGB -> packed HSV {H[8:0], S[6:0], V[7:0]} converter with a matched side-band delay.
// Latency: fixed 4 clocks for pixel_out and pass_thru (one pixel per clock).
// Backpressure: none; a new pixel is accepted every cycle, no stalls.
// Optional RGB2HSV_VALID_EN adds valid_in/valid_out; invalid slots drive zero outputs.
module rgb_to_hsv
  import hsv_pkg::*;
#(
  parameter int PIX_W   = 24,
  parameter int RECIP_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef RGB2HSV_VALID_EN
  input  logic             valid_in,
  output logic             valid_out,
`endif
  input  logic [PIX_W-1:0] pixel_in,
  input  logic [PIX_W-1:0] pass_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic [PIX_W-1:0] pass_thru
);

  localparam int PROD_W = V_W + S_W + RECIP_W;

  // ---------------- stage 1: channel split, max/min/delta ----------------
  logic [V_W-1:0] r_c, g_c, b_c, max_c, min_c;
  max_sel_e       sel_c;

  logic [V_W-1:0] s1_r, s1_g, s1_b, s1_max, s1_delta;
  max_sel_e       s1_sel;

  // Pick the max channel with R, then G, winning ties; track the min alongside.
  always_comb begin
    r_c   = pixel_in[23:16];
    g_c   = pixel_in[15:8];
    b_c   = pixel_in[7:0];
    sel_c = SEL_R;
    max_c = r_c;
    if (r_c >= g_c && r_c >= b_c) begin
      sel_c = SEL_R;
      max_c = r_c;
    end else if (g_c >= b_c) begin
      sel_c = SEL_G;
      max_c = g_c;
    end else begin
      sel_c = SEL_B;
      max_c = b_c;
    end
    min_c = r_c;
    if (g_c < min_c) min_c = g_c;
    if (b_c < min_c) min_c = b_c;
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_max   <= '0;
      s1_delta <= '0;
      s1_sel   <= SEL_R;
    end else begin
      s1_r     <= r_c;
      s1_g     <= g_c;
      s1_b     <= b_c;
      s1_max   <= max_c;
      s1_delta <= max_c - min_c;
      s1_sel   <= sel_c;
    end
  end

  // ---------------- stage 2: reciprocals, signed hue diff, base ----------------
  logic [RECIP_W-1:0] rmax_c, rdel_c;
  logic signed [8:0]  diff_c;
  logic [H_W-1:0]     base_c;

  logic [RECIP_W-1:0] s2_rmax, s2_rdel;
  logic signed [8:0]  s2_diff;
  logic [H_W-1:0]     s2_base;
  logic [V_W-1:0]     s2_delta, s2_max;

  recip_lut #(.RECIP_W(RECIP_W)) u_recip_max (
    .addr  (s1_max),
    .recip (rmax_c)
  );

  recip_lut #(.RECIP_W(RECIP_W)) u_recip_del (
    .addr  (s1_delta),
    .recip (rdel_c)
  );

  // Hue sector: difference of the two non-max channels and the sector base angle.
  always_comb begin
    diff_c = '0;
    base_c = '0;
    case (s1_sel)
      SEL_R: begin
        diff_c = $signed({1'b0, s1_g}) - $signed({1'b0, s1_b});
        base_c = '0;
      end
      SEL_G: begin
        diff_c = $signed({1'b0, s1_b}) - $signed({1'b0, s1_r});
        base_c = H_W'(HUE_G_BASE);
      end
      default: begin
        diff_c = $signed({1'b0, s1_r}) - $signed({1'b0, s1_g});
        base_c = H_W'(HUE_B_BASE);
      end
    endcase
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_rmax  <= '0;
      s2_rdel  <= '0;
      s2_diff  <= '0;
      s2_base  <= '0;
      s2_delta <= '0;
      s2_max   <= '0;
    end else begin
      s2_rmax  <= rmax_c;
      s2_rdel  <= rdel_c;
      s2_diff  <= diff_c;
      s2_base  <= base_c;
      s2_delta <= s1_delta;
      s2_max   <= s1_max;
    end
  end

  // ---------------- stage 3: saturation and hue magnitude ----------------
  logic [8:0]        diff_abs;
  logic [PROD_W-1:0] s_prod, h_prod;
  logic [S_W-1:0]    s_c;
  logic [H_W-1:0]    hmag_c;

  logic [S_W-1:0]    s3_s;
  logic [H_W-1:0]    s3_hmag, s3_base;
  logic              s3_neg, s3_zero;
  logic [V_W-1:0]    s3_max;

  // Full-width products scaled back by 2^16; ceil reciprocals can overshoot, so clamp.
  always_comb begin
    diff_abs = s2_diff[8] ? (~s2_diff + 9'd1) : s2_diff;
    s_prod   = (PROD_W'(s2_delta) * PROD_W'(S_MAX) * PROD_W'(s2_rmax)) >> 16;
    h_prod   = (PROD_W'(HUE_SEG) * PROD_W'(diff_abs) * PROD_W'(s2_rdel)) >> 16;
    s_c      = (s_prod > PROD_W'(S_MAX))   ? S_W'(S_MAX)   : s_prod[S_W-1:0];
    hmag_c   = (h_prod > PROD_W'(HUE_SEG)) ? H_W'(HUE_SEG) : h_prod[H_W-1:0];
  end

  // Stage 3 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_s    <= '0;
      s3_hmag <= '0;
      s3_base <= '0;
      s3_neg  <= 1'b0;
      s3_zero <= 1'b0;
      s3_max  <= '0;
    end else begin
      s3_s    <= s_c;
      s3_hmag <= hmag_c;
      s3_base <= s2_base;
      s3_neg  <= s2_diff[8];
      s3_zero <= (s2_delta == '0);
      s3_max  <= s2_max;
    end
  end

  // ---------------- stage 4: hue assembly and output ----------------
  logic [H_W-1:0]   h_c;
  logic [PIX_W-1:0] pix_c;
  logic             out_ok;

  // Apply the hue sign with wrap into 0..359 using only 9-bit unsigned arithmetic.
  always_comb begin
    h_c = '0;
    if (s3_neg) begin
      if (s3_hmag > s3_base) h_c = H_W'(HUE_FULL) - (s3_hmag - s3_base);
      else                   h_c = s3_base - s3_hmag;
    end else begin
      h_c = s3_base + s3_hmag;
    end
    if (h_c == H_W'(HUE_FULL)) h_c = '0;
    if (s3_zero) pix_c = {{H_W{1'b0}}, {S_W{1'b0}}, s3_max};
    else         pix_c = {h_c, s3_s, s3_max};
  end

  // Side-band delay line, one entry short of the output register.
  logic [PIX_W-1:0] pass_pipe [RGB2HSV_LAT-1];

  // Side-band shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RGB2HSV_LAT - 1; i++) pass_pipe[i] <= '0;
    end else begin
      pass_pipe[0] <= pass_in;
      for (int i = 1; i < RGB2HSV_LAT - 1; i++) pass_pipe[i] <= pass_pipe[i-1];
    end
  end

`ifdef RGB2HSV_VALID_EN
  logic [RGB2HSV_LAT-2:0] vld_pipe;

  // Valid rides alongside the pixel so the output register can blank invalid slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      valid_out <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[RGB2HSV_LAT-3:0], valid_in};
      valid_out <= vld_pipe[RGB2HSV_LAT-2];
    end
  end

  assign out_ok = vld_pipe[RGB2HSV_LAT-2];
`else
  assign out_ok = 1'b1;
`endif

  // Output register; invalid slots are forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out <= '0;
      pass_thru <= '0;
    end else begin
      pixel_out <= out_ok ? pix_c : '0;
      pass_thru <= out_ok ? pass_pipe[RGB2HSV_LAT-2] : '0;
    end
  end

endmodule

// File: tb/tb_rgb_to_hsv.sv
// Self-checking bench for rgb_to_hsv: directed colours, randomized pixels
// against an integer reference model, mid-stream async reset, optional valid.
module tb_rgb_to_hsv;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        valid_out;
  logic [23:0] pixel_in;
  logic [23:0] pass_in;
  logic [23:0] pixel_out;
  logic [23:0] pass_thru;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] pix;
    logic [23:0] pas;
    logic        vld;
  } exp_t;

  exp_t expq[$];

  rgb_to_hsv dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef RGB2HSV_VALID_EN
    .valid_in  (valid_in),
    .valid_out (valid_out),
`endif
    .pixel_in  (pixel_in),
    .pass_in   (pass_in),
    .pixel_out (pixel_out),
    .pass_thru (pass_thru)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: HSV from the written rules using plain integer arithmetic.
  function automatic logic [23:0] model_hsv(input logic [23:0] p);
    int r, g, b, mx, mn, d, rmax, rdel, diff, base, s, hm, h, ad;
    longint sp, hp;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    d = mx - mn;
    if (d == 0) return {9'd0, 7'd0, 8'(mx)};
    rmax = 65536 / mx;
    if (rmax * mx != 65536) rmax = rmax + 1;
    rdel = 65536 / d;
    if (rdel * d != 65536) rdel = rdel + 1;
    if (r == mx)      begin diff = g - b; base = 0;   end
    else if (g == mx) begin diff = b - r; base = 120; end
    else              begin diff = r - g; base = 240; end
    ad = (diff < 0) ? -diff : diff;
    sp = (longint'(d) * 127 * longint'(rmax)) >>> 16;
    hp = (longint'(60) * longint'(ad) * longint'(rdel)) >>> 16;
    s  = (sp > 127) ? 127 : int'(sp);
    hm = (hp > 60) ? 60 : int'(hp);
    h  = (diff < 0) ? base - hm : base + hm;
    if (h < 0) h = h + 360;
    if (h == 360) h = 0;
    return {9'(h), 7'(s), 8'(mx)};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One pixel slot: check what left the pipe four slots ago, then drive the next input.
  task automatic step(input logic [23:0] pix, input logic [23:0] pas, input logic v);
    exp_t e, n;
    logic eff_v;
    @(negedge clk);
    e = expq.pop_front();
    chk("pixel_out", pixel_out, e.pix);
    chk("pass_thru", pass_thru, e.pas);
`ifdef RGB2HSV_VALID_EN
    chk("valid_out", {23'd0, valid_out}, {23'd0, e.vld});
    eff_v = v;
`else
    eff_v = 1'b1;
`endif
    pixel_in = pix;
    pass_in  = pas;
    valid_in = v;
    n.vld = eff_v;
    n.pix = eff_v ? model_hsv(pix) : 24'h0;
    n.pas = eff_v ? pas : 24'h0;
    expq.push_back(n);
  endtask

  task automatic prefill_zero();
    exp_t z;
    z.pix = 24'h0;
    z.pas = 24'h0;
    z.vld = 1'b0;
    expq.delete();
    for (int i = 0; i < 4; i++) expq.push_back(z);
  endtask

  function automatic logic [7:0] pick_chan();
    logic [7:0] tbl [6];
    tbl[0] = 8'd0;   tbl[1] = 8'd1;   tbl[2] = 8'd127;
    tbl[3] = 8'd128; tbl[4] = 8'd254; tbl[5] = 8'd255;
    return tbl[$urandom_range(0, 5)];
  endfunction

  initial begin
    logic [23:0] rp;
    rst_n    = 1'b0;
    pixel_in = 24'h0;
    pass_in  = 24'h0;
    valid_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_pixel", pixel_out, 24'h0);
    chk("reset_pass", pass_thru, 24'h0);
    rst_n = 1'b1;
    prefill_zero();

    // Primary colours, R/G tie, negative-wrap hue, grey and black
    step(24'hFF0000, 24'hABCDEF, 1'b1);
    step(24'h00FF00, 24'h000001, 1'b1);
    step(24'h0000FF, 24'h000002, 1'b1);
    step(24'hFFFF00, 24'h000003, 1'b1);
    step(24'hFF00FF, 24'h000004, 1'b1);
    step(24'h808080, 24'h000005, 1'b1);
    step(24'h000000, 24'h000006, 1'b1);
    step(24'h000000, 24'h000000, 1'b1);
    // Fixed expectations, independent of the model, for the directed colours
    chk("first_red_model", model_hsv(24'hFF0000), 24'h007FFF);
    chk("neg_wrap_model", model_hsv(24'hFF00FF), {9'd300, 7'd127, 8'd255});
    for (int i = 0; i < 3; i++) step(24'h000000, 24'h000000, 1'b1);

    // Valid pattern 1,0,1
    step(24'h00FF00, 24'h111111, 1'b1);
    step(24'h0000FF, 24'h222222, 1'b0);
    step(24'hFFFF00, 24'h333333, 1'b1);

    // Randomized pixels, half drawn from edge channel values to hit ties
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) rp = 24'($urandom);
      else            rp = {pick_chan(), pick_chan(), pick_chan()};
      step(rp, 24'($urandom) | 24'h1, 1'b1);
    end

    // Asynchronous reset mid-stream while the pipe is full
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pixel", pixel_out, 24'h0);
    chk("async_rst_pass", pass_thru, 24'h0);
`ifdef RGB2HSV_VALID_EN
    chk("async_rst_valid", {23'd0, valid_out}, 24'h0);
`endif
    pixel_in = 24'h0;
    pass_in  = 24'h0;
    valid_in = 1'b0;
    @(negedge clk);
    chk("held_rst_pixel", pixel_out, 24'h0);
    chk("held_rst_pass", pass_thru, 24'h0);
    rst_n = 1'b1;
    prefill_zero();

    // Post-release traffic, then drain
    step(24'h0000FF, 24'h0F0F0F, 1'b1);
    for (int i = 0; i < 20; i++) step(24'($urandom), 24'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) step(24'h000000, 24'h000000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
